// File: rtl/bottle_sequencer.sv
// Filling-station sequencer: conveyor advance, settle, pill fill, release,
// with conveyor-timeout, pill-jam and bottle-lost fault detection.
module bottle_sequencer #(
    parameter int CONVEY_TIMEOUT = 1000,
    parameter int SETTLE_CYCLES  = 16,
    parameter int JAM_TIMEOUT    = 500
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       working,
    input  logic       finished,
    input  logic       bottle_present,
    input  logic       pill_pulse,
    input  logic [7:0] pill_setting,
    input  logic       clear_fault,
    output logic       conveyor_run,
    output logic       gate_open,
    output logic       bottle_done,
    output logic [7:0] pill_count,
    output logic       fault,
    output logic [1:0] fault_code
);

    localparam int MAX_CT = (CONVEY_TIMEOUT > JAM_TIMEOUT) ?
                            ((CONVEY_TIMEOUT > SETTLE_CYCLES) ? CONVEY_TIMEOUT : SETTLE_CYCLES) :
                            ((JAM_TIMEOUT > SETTLE_CYCLES) ? JAM_TIMEOUT : SETTLE_CYCLES);
    localparam int TW = $clog2(MAX_CT) + 1;

    localparam logic [TW-1:0] CONVEY_LAST = TW'(CONVEY_TIMEOUT - 1);
    localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] JAM_LAST    = TW'(JAM_TIMEOUT - 1);

    localparam logic [1:0] FC_NONE   = 2'b00;
    localparam logic [1:0] FC_CONVEY = 2'b01;
    localparam logic [1:0] FC_JAM    = 2'b10;
    localparam logic [1:0] FC_LOST   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADVANCE,
        S_SETTLE,
        S_FILL,
        S_RELEASE,
        S_FAULT
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]    pill_count_q, pill_count_d;
    logic [1:0]    fault_code_q, fault_code_d;
    logic          conveyor_run_q, conveyor_run_d;
    logic          gate_open_q, gate_open_d;
    logic          bottle_done_q, bottle_done_d;
    logic          fault_q, fault_d;
    logic [7:0]    pill_next;

    assign pill_next = pill_count_q + 8'd1;

    // Next-state, timer, counter and registered-output decode
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        pill_count_d = pill_count_q;
        fault_code_d = fault_code_q;
        bottle_done_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (working && !finished) state_d = S_ADVANCE;
            end
            S_ADVANCE: begin
                timer_d = timer_q + 1'b1;
                if (!working)                  state_d = S_IDLE;
                else if (bottle_present)       state_d = S_SETTLE;
                else if (timer_q == CONVEY_LAST) begin
                    state_d      = S_FAULT;
                    fault_code_d = FC_CONVEY;
                end
            end
            S_SETTLE: begin
                timer_d = timer_q + 1'b1;
                if (!working)             state_d = S_IDLE;
                else if (!bottle_present) state_d = S_ADVANCE;
                else if (timer_q == SETTLE_LAST) begin
                    pill_count_d = 8'd0;
                    state_d      = (pill_setting == 8'd0) ? S_RELEASE : S_FILL;
                end
            end
            S_FILL: begin
                // Losing the bottle beats everything, even a pause.
                if (!bottle_present) begin
                    state_d      = S_FAULT;
                    fault_code_d = FC_LOST;
                end else if (working) begin
                    if (pill_pulse) begin
                        pill_count_d = pill_next;
                        timer_d      = '0;
                        // >= so a live drop of pill_setting still finishes the bottle
                        if (pill_next >= pill_setting) state_d = S_RELEASE;
                    end else if (timer_q == JAM_LAST) begin
                        state_d      = S_FAULT;
                        fault_code_d = FC_JAM;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end
            S_RELEASE: begin
                // working is ignored here so the bottle always leaves.
                timer_d = timer_q + 1'b1;
                if (!bottle_present) begin
                    state_d       = S_IDLE;
                    bottle_done_d = 1'b1;
                end else if (timer_q == CONVEY_LAST) begin
                    state_d      = S_FAULT;
                    fault_code_d = FC_CONVEY;
                end
            end
            S_FAULT: begin
                if (clear_fault) begin
                    state_d      = S_IDLE;
                    fault_code_d = FC_NONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d != state_q) timer_d = '0;

        conveyor_run_d = (state_d == S_ADVANCE) || (state_d == S_RELEASE);
        gate_open_d    = (state_d == S_FILL) && working;
        fault_d        = (state_d == S_FAULT);
    end

    // State and output registers, async active-low reset to IDLE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            timer_q        <= '0;
            pill_count_q   <= 8'd0;
            fault_code_q   <= FC_NONE;
            conveyor_run_q <= 1'b0;
            gate_open_q    <= 1'b0;
            bottle_done_q  <= 1'b0;
            fault_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            pill_count_q   <= pill_count_d;
            fault_code_q   <= fault_code_d;
            conveyor_run_q <= conveyor_run_d;
            gate_open_q    <= gate_open_d;
            bottle_done_q  <= bottle_done_d;
            fault_q        <= fault_d;
        end
    end

    assign conveyor_run = conveyor_run_q;
    assign gate_open    = gate_open_q;
    assign bottle_done  = bottle_done_q;
    assign pill_count   = pill_count_q;
    assign fault        = fault_q;
    assign fault_code   = fault_code_q;

endmodule

// File: tb/tb_bottle_sequencer.sv
// Directed bench for bottle_sequencer with hand-computed expected outputs.
module tb_bottle_sequencer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       working = 1'b0;
    logic       finished = 1'b0;
    logic       bottle_present = 1'b0;
    logic       pill_pulse = 1'b0;
    logic [7:0] pill_setting = 8'd0;
    logic       clear_fault = 1'b0;
    logic       conveyor_run, gate_open, bottle_done, fault;
    logic [7:0] pill_count;
    logic [1:0] fault_code;

    int tests = 0;
    int fails = 0;

    bottle_sequencer dut (
        .clk(clk), .reset_n(reset_n), .working(working), .finished(finished),
        .bottle_present(bottle_present), .pill_pulse(pill_pulse),
        .pill_setting(pill_setting), .clear_fault(clear_fault),
        .conveyor_run(conveyor_run), .gate_open(gate_open),
        .bottle_done(bottle_done), .pill_count(pill_count),
        .fault(fault), .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    // {conveyor_run, gate_open, bottle_done, fault, fault_code[1:0]}
    wire [5:0] outs = {conveyor_run, gate_open, bottle_done, fault, fault_code};

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic pulse();
        pill_pulse = 1'b1;
        tick();
        pill_pulse = 1'b0;
    endtask

    initial begin
        // Reset state
        tick(2);
        chk("reset_outs", {2'b00, outs}, 8'b00_000000);
        chk("reset_count", pill_count, 8'd0);
        #2 reset_n = 1'b1;

        // Nominal bottle, pill_setting=3
        pill_setting = 8'd3;
        working = 1'b1;
        tick();
        chk("nom_advance", {2'b00, outs}, 8'b00_100000);
        tick(4);
        bottle_present = 1'b1;
        tick();
        chk("nom_settle", {2'b00, outs}, 8'b00_000000);
        tick(15);
        chk("nom_settle_end", {2'b00, outs}, 8'b00_000000);
        tick();
        chk("nom_fill", {2'b00, outs}, 8'b00_010000);
        chk("nom_fill_cnt", pill_count, 8'd0);
        pulse(); tick(2);
        pulse(); tick();
        chk("nom_p2_gate", {2'b00, outs}, 8'b00_010000);
        chk("nom_p2_cnt", pill_count, 8'd2);
        pulse();
        chk("nom_release", {2'b00, outs}, 8'b00_100000);
        chk("nom_cnt3", pill_count, 8'd3);
        tick(3);
        bottle_present = 1'b0;
        tick();
        chk("nom_done", {2'b00, outs}, 8'b00_001000);
        tick();
        chk("nom_readvance", {2'b00, outs}, 8'b00_100000);
        chk("nom_cnt_hold", pill_count, 8'd3);

        // Zero setting: SETTLE straight to RELEASE
        pill_setting = 8'd0;
        bottle_present = 1'b1;
        tick(17);
        chk("zero_release", {2'b00, outs}, 8'b00_100000);
        chk("zero_cnt", pill_count, 8'd0);
        bottle_present = 1'b0;
        tick();
        chk("zero_done", {2'b00, outs}, 8'b00_001000);
        tick();
        chk("zero_readvance", {2'b00, outs}, 8'b00_100000);

        // Jam: 2 pulses, then silence for 500 cycles
        pill_setting = 8'd5;
        bottle_present = 1'b1;
        tick(17);
        chk("jam_fill", {2'b00, outs}, 8'b00_010000);
        pulse(); pulse();
        tick(499);
        chk("jam_pre", {2'b00, outs}, 8'b00_010000);
        tick();
        chk("jam_fault", {2'b00, outs}, 8'b00_000110);
        chk("jam_cnt", pill_count, 8'd2);
        bottle_present = 1'b0;
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        chk("jam_clear", {2'b00, outs}, 8'b00_000000);
        chk("jam_cnt_kept", pill_count, 8'd2);

        // clear_fault outside FAULT does nothing; then bottle lost in FILL
        tick();
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        chk("clr_noeffect", {2'b00, outs}, 8'b00_100000);
        bottle_present = 1'b1;
        tick(17);
        chk("lost_fill", {2'b00, outs}, 8'b00_010000);
        bottle_present = 1'b0;
        tick();
        chk("lost_fault", {2'b00, outs}, 8'b00_000111);
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        chk("lost_clear", {2'b00, outs}, 8'b00_000000);

        // Settle bounce: sensor high 10 cycles then low -> back to ADVANCE
        tick();
        bottle_present = 1'b1;
        tick(10);
        chk("bounce_settle", {2'b00, outs}, 8'b00_000000);
        bottle_present = 1'b0;
        tick();
        chk("bounce_advance", {2'b00, outs}, 8'b00_100000);

        // Pause during FILL with pill_setting=4
        pill_setting = 8'd4;
        bottle_present = 1'b1;
        tick(17);
        chk("pause_fill", {2'b00, outs}, 8'b00_010000);
        pulse();
        working = 1'b0;
        tick();
        chk("pause_gate", {2'b00, outs}, 8'b00_000000);
        pulse(); pulse();
        tick(600);
        chk("pause_ignored", {2'b00, outs}, 8'b00_000000);
        chk("pause_cnt", pill_count, 8'd1);
        working = 1'b1;
        tick();
        chk("pause_resume", {2'b00, outs}, 8'b00_010000);
        pulse(); pulse(); pulse();
        chk("pause_release", {2'b00, outs}, 8'b00_100000);
        chk("pause_cnt4", pill_count, 8'd4);
        finished = 1'b1;
        bottle_present = 1'b0;
        tick();
        chk("fin_done", {2'b00, outs}, 8'b00_001000);
        tick(3);
        chk("fin_idle", {2'b00, outs}, 8'b00_000000);

        // Conveyor timeout: 1000 cycles with no bottle
        finished = 1'b0;
        tick();
        chk("to_advance", {2'b00, outs}, 8'b00_100000);
        tick(999);
        chk("to_pre", {2'b00, outs}, 8'b00_100000);
        tick();
        chk("to_fault", {2'b00, outs}, 8'b00_000101);
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        chk("to_clear", {2'b00, outs}, 8'b00_000000);

        // Asynchronous reset in the middle of FILL
        tick();
        bottle_present = 1'b1;
        tick(17);
        chk("rst_fill", {2'b00, outs}, 8'b00_010000);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_async_outs", {2'b00, outs}, 8'b00_000000);
        chk("rst_async_cnt", pill_count, 8'd0);
        working = 1'b0;
        bottle_present = 1'b0;
        tick();
        #2 reset_n = 1'b1;
        working = 1'b1;
        tick();
        chk("rst_idle_to_adv", {2'b00, outs}, 8'b00_100000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute bound so the run always ends
    initial begin
        #2000000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
